// File: rtl/armleocpu_operand_fetch.sv
// Operand-fetch stage: holds one decoded instruction, waits out RAW/WAW hazards
// tracked in a 32-entry in-flight scoreboard, reads the register file and hands off to execute.
module armleocpu_operand_fetch (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_pc,
  input  logic [31:0] s_instr,
  input  logic        s_rs1_used,
  input  logic        s_rs2_used,
  input  logic        s_rd_used,
  input  logic [4:0]  s_rs1_addr,
  input  logic [4:0]  s_rs2_addr,
  input  logic [4:0]  s_rd_addr,

  output logic        rs1_read,
  output logic        rs2_read,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,

  input  logic        wb_rd_write,
  input  logic [4:0]  wb_rd_addr,

  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_pc,
  output logic [31:0] m_instr,
  output logic [31:0] m_rs1_data,
  output logic [31:0] m_rs2_data,
  output logic        m_rd_write,
  output logic [4:0]  m_rd_addr,

  input  logic        flush,
  input  logic        sb_clear
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_rs1_used;
  logic        r_rs2_used;
  logic        r_rd_used;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd_addr;
  logic        r_rs1_issued;
  logic        r_rs2_issued;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;

  logic [31:1] r_sb_bits;
  logic [31:0] w_sb;

  logic        w_rs1_need;
  logic        w_rs2_need;
  logic        w_rd_need;
  logic        w_hazard;
  logic        w_issue;
  logic        w_accept;
  logic        w_handshake;
  logic        w_sb_set;

  // x0 never has a write in flight, so its bit is hard-wired to zero.
  assign w_sb = {r_sb_bits, 1'b0};

  assign w_rs1_need = r_rs1_used && (r_rs1_addr != 5'd0);
  assign w_rs2_need = r_rs2_used && (r_rs2_addr != 5'd0);
  assign w_rd_need  = r_rd_used  && (r_rd_addr  != 5'd0);

  assign w_hazard = (w_rs1_need && w_sb[r_rs1_addr])
                 || (w_rs2_need && w_sb[r_rs2_addr])
                 || (w_rd_need  && w_sb[r_rd_addr]);

  assign w_issue  = (r_state == ST_HOLD) && !w_hazard && !flush;
  assign rs1_read = w_issue && w_rs1_need;
  assign rs2_read = w_issue && w_rs2_need;
  assign rs1_addr = r_rs1_addr;
  assign rs2_addr = r_rs2_addr;

  assign s_ready     = !flush && ((r_state == ST_IDLE) || ((r_state == ST_OUT) && m_ready));
  assign w_accept    = s_valid && s_ready;
  assign m_valid     = (r_state == ST_OUT);
  assign w_handshake = (r_state == ST_OUT) && m_ready && !flush;
  assign w_sb_set    = w_handshake && w_rd_need;

  assign m_pc       = r_pc;
  assign m_instr    = r_instr;
  assign m_rs1_data = r_rs1_data;
  assign m_rs2_data = r_rs2_data;
  assign m_rd_write = r_rd_used;
  assign m_rd_addr  = r_rd_addr;

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_accept) w_state_next = ST_HOLD;
        ST_HOLD:   if (!w_hazard) w_state_next = ST_RDWAIT;
        ST_RDWAIT: w_state_next = ST_OUT;
        ST_OUT:    if (m_ready) w_state_next = w_accept ? ST_HOLD : ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= 32'd0;
      r_instr      <= 32'd0;
      r_rs1_used   <= 1'b0;
      r_rs2_used   <= 1'b0;
      r_rd_used    <= 1'b0;
      r_rs1_addr   <= 5'd0;
      r_rs2_addr   <= 5'd0;
      r_rd_addr    <= 5'd0;
      r_rs1_issued <= 1'b0;
      r_rs2_issued <= 1'b0;
      r_rs1_data   <= 32'd0;
      r_rs2_data   <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_rs1_issued <= rs1_read;
      r_rs2_issued <= rs2_read;
      if (w_accept) begin
        r_pc       <= s_pc;
        r_instr    <= s_instr;
        r_rs1_used <= s_rs1_used;
        r_rs2_used <= s_rs2_used;
        r_rd_used  <= s_rd_used;
        r_rs1_addr <= s_rs1_addr;
        r_rs2_addr <= s_rs2_addr;
        r_rd_addr  <= s_rd_addr;
      end
      // Read data is valid the cycle after the enable; operands not read are forced to zero.
      if (r_state == ST_RDWAIT) begin
        r_rs1_data <= r_rs1_issued ? rs1_rdata : 32'd0;
        r_rs2_data <= r_rs2_issued ? rs2_rdata : 32'd0;
      end
    end
  end

  // Per-register in-flight bits: a completing handshake's set beats writeback and bulk clear.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_sb
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sb_bits[gi] <= 1'b0;
        end else if (w_sb_set && (r_rd_addr == 5'(gi))) begin
          r_sb_bits[gi] <= 1'b1;
        end else if (sb_clear || (wb_rd_write && (wb_rd_addr == 5'(gi)))) begin
          r_sb_bits[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: doc/armleocpu_operand_fetch.md
Name: armleocpu_operand_fetch

Overview:
- Single-entry operand-fetch stage between decode and execute.
- Accepts one decoded instruction at a time and keeps a 32-bit scoreboard of registers with writes still in flight.
- Stalls on RAW/WAW hazards, reads rs1/rs2 from the register file's synchronous read ports, and presents the instruction plus captured operands to execute over a valid/ready handshake.

Parameters:
- None. Register file is fixed at 32 x 32 bit.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  decode offers instruction
- s_ready  output  1  stage accepts instruction
- s_pc  input  32  instruction PC
- s_instr  input  32  instruction word, carried through unchanged
- s_rs1_used, s_rs2_used, s_rd_used  input  1 each  operand/dest usage flags
- s_rs1_addr, s_rs2_addr, s_rd_addr  input  5 each  register indices
- rs1_read, rs2_read  output  1 each  register-file read enables
- rs1_addr, rs2_addr  output  5 each  register-file read addresses
- rs1_rdata, rs2_rdata  input  32 each  register-file read data; valid the cycle after the read enable, held while the enable is low
- wb_rd_write  input  1  writeback commits a register write (same signal the register file sees)
- wb_rd_addr  input  5  writeback destination
- m_valid  output  1  operands ready for execute
- m_ready  input  1  execute accepts
- m_pc, m_instr  output  32 each  registered copies
- m_rs1_data, m_rs2_data  output  32 each  captured operands
- m_rd_write  output  1  registered s_rd_used
- m_rd_addr  output  5  registered destination
- flush  input  1  synchronous kill of the held instruction
- sb_clear  input  1  synchronous clear of the whole scoreboard

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, scoreboard = 0.
  - m_valid, rs1_read and rs2_read = 0.
  - All m_* data registers = 0.
- State machine: IDLE, HOLD, RDWAIT, OUT.
  - IDLE: s_ready = 1. On s_valid, latch all s_* fields, go to HOLD.
  - HOLD: compute hazard from the registered scoreboard:
    - rs1_used && rs1 != 0 && sb[rs1]
    - rs2_used && rs2 != 0 && sb[rs2]
    - rd_used && rd != 0 && sb[rd]
    - If any hazard is set, stay in HOLD with no reads.
    - Otherwise assert rsX_read for each used, non-zero operand (addresses driven from the latched fields) and go to RDWAIT.
  - RDWAIT: at the cycle end, capture m_rsX_data = rsX_rdata if that read was issued, else 0 (x0 and unused operands read as 0). Go to OUT.
  - OUT: m_valid = 1; all m_* outputs stable until the handshake.
    - On m_valid && m_ready: if s_valid, accept the next instruction (s_ready = m_ready in OUT) and go to HOLD; else go to IDLE.
  - s_ready = 0 in HOLD and RDWAIT.
- Latency: accept at edge T, reads issued in cycle T+1 (no hazard), m_valid high from cycle T+3. Peak throughput is 1 instruction per 3 cycles.
- Scoreboard:
  - Set sb[m_rd_addr] on a completed handshake with m_rd_write && m_rd_addr != 0.
  - Clear sb[a] when wb_rd_write && wb_rd_addr == a.
  - Set and clear of the same index in the same cycle: set wins.
  - sb_clear zeroes all bits; a same-cycle set is still applied.
  - sb[0] is always 0.
  - A clear in cycle C unblocks reads at C+1, so a read never coincides with the write it waits on.
- flush (synchronous, highest priority):
  - Next state = IDLE; s_ready = 0 during the flush cycle.
  - An m handshake in the flush cycle is not counted and sets no scoreboard bit. Execute gates its own acceptance with flush.
  - flush does not touch the scoreboard; the owner asserts sb_clear once the downstream pipeline has drained.
- Reset mid-operation drops the held instruction and clears the scoreboard immediately.

Test Plan:
- Accept pc=0x100, rs1=5, rs2=6, rd=7 with empty scoreboard; regfile x5=0x11, x6=0x22 -> rs1_read/rs2_read in cycle T+1; m_valid in cycle T+3 with m_rs1_data=0x11, m_rs2_data=0x22; after handshake sb[7]=1.
- Second instruction reads x7 while sb[7]=1 -> held in HOLD with no reads; wb_rd_write with addr 7 in cycle C -> reads issued in C+1, output returns the new x7 value.
- Instruction with rs1=0, rs2 unused, rd=0 -> no reads issued, m_rs1_data=m_rs2_data=0, no scoreboard bit set after handshake.
- Hold m_ready=0 for 4 cycles in OUT while wb writes the same register -> m_* outputs unchanged; m_ready=1 with s_valid=1 -> next instruction accepted in the same cycle.
- flush in RDWAIT and flush coincident with an m handshake -> returns to IDLE, m_valid=0, no scoreboard bit set; sb_clear with a same-cycle set of rd=3 -> only sb[3]=1.
- rst_n low while in OUT with sb[9]=1 -> m_valid=0, scoreboard=0 immediately, state IDLE, s_ready=1 after release.
